// File: rtl/fifo_stage_pkg.sv
// Shared types and sizing helpers for the sync_fifo pop stage and its skid buffer.
package fifo_stage_pkg;

  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  // Occupancy must be able to represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/asserts_fifo_pop_stage.sv
// Companion checker for fifo_pop_stage; observes ports only and rebuilds the
// in-flight flag from fifo_read itself.
module asserts_fifo_pop_stage
  import fifo_stage_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = 2
) (
  input logic                         clk,
  input logic                         rst,
  input logic                         flush,
  input logic                         fifo_empty,
  input logic                         fifo_read,
  input logic                         out_valid,
  input logic                         out_ready,
  input logic [WIDTH-1:0]             out_data,
  input logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int CW = occ_width(DEPTH);

  logic             inflight_r;
  logic             hold_r;
  logic [WIDTH-1:0] data_r;
  logic             arrive_s;

  always_comb begin
    arrive_s = inflight_r && !flush && !rst;
  end

  // Track last-cycle state and check the buffer contract at every edge.
  always_ff @(posedge clk) begin
    inflight_r <= fifo_read && !rst && !flush;
    hold_r     <= out_valid && !out_ready && !rst && !flush;
    data_r     <= out_data;
    assert (!(arrive_s && (occupancy == CW'(DEPTH))));
    assert (!(fifo_read && fifo_empty));
    if (hold_r) begin
      assert (out_valid && (out_data == data_r));
    end
  end

endmodule

// File: rtl/skid_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module skid_ram
  import fifo_stage_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = 2,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PW-1:0]    wptr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    rptr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage: cleared on reset so the presented head word reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[wptr] <= wdata;
    end else begin
      mem_r <= mem_r;
    end
  end

  assign rdata = mem_r[rptr];

endmodule

// File: rtl/fifo_pop_stage.sv
// Pops words from a registered-read sync_fifo into a credit-managed skid buffer
// and presents them as a valid/ready stream.
module fifo_pop_stage
  import fifo_stage_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_empty,
  input  logic [WIDTH-1:0]             fifo_rdData,
  output logic                         fifo_read,
  input  logic                         flush,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int CW = occ_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [CW-1:0]    occ_r;
  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic             inflight_r;
  logic             valid_r;
  logic             pop_s;
  logic             arrive_s;
  logic             read_s;
  logic             ram_we_s;
  logic [CW:0]      committed_s;
  logic [CW:0]      limit_s;
  logic [WIDTH-1:0] head_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Credit check: words held plus the one in flight, less the one leaving now,
  // must leave room; compared as occ+inflight < DEPTH+pop to avoid underflow.
  always_comb begin
    pop_s       = valid_r && out_ready;
    arrive_s    = inflight_r && !flush;
    ram_we_s    = arrive_s && !rst;
    committed_s = {1'b0, occ_r} + {{CW{1'b0}}, inflight_r};
    limit_s     = (CW + 1)'(DEPTH) + {{CW{1'b0}}, pop_s};
    if (rst || flush || fifo_empty) begin
      read_s = 1'b0;
    end else begin
      read_s = (committed_s < limit_s);
    end
  end

  // Pointer, occupancy and in-flight tracking; flush behaves like a local reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_r      <= '0;
      wptr_r     <= '0;
      rptr_r     <= '0;
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      inflight_r <= read_s;
      if (arrive_s) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (pop_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      case ({arrive_s, pop_s})
        2'b10: begin
          occ_r   <= occ_r + CW'(1);
          valid_r <= 1'b1;
        end
        2'b01: begin
          occ_r   <= occ_r - CW'(1);
          valid_r <= (occ_r != CW'(1));
        end
        default: begin
          occ_r   <= occ_r;
          valid_r <= valid_r;
        end
      endcase
    end
  end

  skid_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_s),
    .wptr  (wptr_r),
    .wdata (fifo_rdData),
    .rptr  (rptr_r),
    .rdata (head_s)
  );

  assign fifo_read = read_s;
  assign out_valid = valid_r;
  assign out_data  = head_s;
  assign occupancy = occ_r;

endmodule

// File: tb/tb_fifo_pop_stage.sv
// Bench for fifo_pop_stage: directed vector table on a DEPTH=2 instance plus
// randomized traffic on a DEPTH=3 instance checked against a word-count model.
module tb_fifo_pop_stage;
  import fifo_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic        fifo_clr = 1'b0;
  logic        fifo_empty, fifo_read, out_valid;
  word_t       rd_data = '0, out_data;
  logic [1:0]  occupancy;

  logic        ready3 = 1'b0;
  logic        fifo_empty3, fifo_read3, out_valid3;
  word_t       rd_data3 = '0, out_data3;
  logic [1:0]  occupancy3;

  int nchecks = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Behavioural registered-read sync_fifo models
  word_t fmem  [1024];
  word_t fmem3 [1024];
  int head = 0, tail = 0, head3 = 0, tail3 = 0;
  assign fifo_empty  = (head == tail);
  assign fifo_empty3 = (head3 == tail3);

  always @(posedge clk) begin
    if (fifo_clr) head <= tail;
    else if (fifo_read) begin
      rd_data <= fmem[head[9:0]];
      head <= head + 1;
    end
  end

  always @(posedge clk) begin
    if (fifo_read3) begin
      rd_data3 <= fmem3[head3[9:0]];
      head3 <= head3 + 1;
    end
  end

  task automatic push(input word_t w);
    fmem[tail[9:0]] = w;
    tail = tail + 1;
  endtask

  task automatic push3(input word_t w);
    fmem3[tail3[9:0]] = w;
    tail3 = tail3 + 1;
  endtask

  fifo_pop_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdData(rd_data),
    .fifo_read(fifo_read), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_ready(ready), .occupancy(occupancy)
  );

  fifo_pop_stage #(.WIDTH(32), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty3), .fifo_rdData(rd_data3),
    .fifo_read(fifo_read3), .flush(1'b0), .out_valid(out_valid3),
    .out_data(out_data3), .out_ready(ready3), .occupancy(occupancy3)
  );

  asserts_fifo_pop_stage #(.WIDTH(32), .DEPTH(2)) chk (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .out_valid(out_valid), .out_ready(ready),
    .out_data(out_data), .occupancy(occupancy)
  );

  asserts_fifo_pop_stage #(.WIDTH(32), .DEPTH(3)) chk3 (
    .clk(clk), .rst(rst), .flush(1'b0), .fifo_empty(fifo_empty3),
    .fifo_read(fifo_read3), .out_valid(out_valid3), .out_ready(ready3),
    .out_data(out_data3), .occupancy(occupancy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        push;
    word_t       pdata;
    logic        rdy;
    logic        fl;
    logic        exp_read;
    logic        exp_valid;
    logic        chk_data;
    word_t       exp_data;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic p, input word_t pd, input logic r, input logic f,
                     input logic er, input logic ev, input word_t ed, input int eo);
    vec_t v;
    v.push = p; v.pdata = pd; v.rdy = r; v.fl = f;
    v.exp_read = er; v.exp_valid = ev; v.chk_data = ev; v.exp_data = ed;
    v.exp_occ = 2'(eo);
    vecs.push_back(v);
  endtask

  initial begin
    word_t w;
    word_t expq[$];
    int pushed, delivered, occm, cyc;
    logic infm, acc;

    // Streaming 1..8 with ready held high, starting the cycle reset drops
    for (int c = 0; c < 12; c++) begin
      add(1'b0, '0, 1'b1, 1'b0, c < 8, (c >= 2 && c < 10), word_t'(c - 1),
          (c >= 2 && c < 10) ? 1 : 0);
    end
    // Backpressure: A,B,C queued while ready is low
    add(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, '0,    0);
    add(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, '0,    0);
    add(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 1);
    add(1'b0, '0,    1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 2);
    add(1'b0, '0,    1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 2);
    add(1'b0, '0,    1'b1, 1'b0, 1'b1, 1'b1, 32'hA, 2);
    add(1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 1);
    add(1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b1, 32'hC, 1);
    add(1'b0, '0,    1'b1, 1'b0, 1'b0, 1'b0, '0,    0);
    // Empty boundary: a single word then nothing
    add(1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0, '0,     0);
    add(1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b0, '0,     0);
    add(1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 1);
    add(1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b0, '0,     0);
    add(1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b0, '0,     0);
    // Flush while a popped word is in flight
    add(1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 1'b0, '0,     0);
    add(1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0, '0,     0);
    add(1'b0, '0,     1'b1, 1'b0, 1'b1, 1'b0, '0,     0);
    add(1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b0, '0,     0);
    add(1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 1);
    add(1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b0, '0,     0);

    for (int i = 1; i <= 8; i++) push(word_t'(i));
    repeat (2) begin
      @(negedge clk); #1;
      check("reset read", 32'(fifo_read), 32'd0);
      check("reset valid", 32'(out_valid), 32'd0);
      check("reset occ", 32'(occupancy), 32'd0);
      check("reset data", out_data, 32'd0);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = 1'b0;
      ready = vecs[i].rdy;
      flush = vecs[i].fl;
      if (vecs[i].push) push(vecs[i].pdata);
      #1;
      check($sformatf("vec%0d read", i), 32'(fifo_read), 32'(vecs[i].exp_read));
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d occ", i), 32'(occupancy), 32'(vecs[i].exp_occ));
      if (vecs[i].chk_data) check($sformatf("vec%0d data", i), out_data, vecs[i].exp_data);
    end

    // Reset together with flush while a word is in flight and one is buffered
    @(negedge clk); flush = 1'b0; ready = 1'b0;
    push(32'h11); push(32'h22); push(32'h33); #1;
    check("mid read0", 32'(fifo_read), 32'd1);
    @(negedge clk); #1;
    check("mid read1", 32'(fifo_read), 32'd1);
    @(negedge clk); #1;
    check("mid valid", 32'(out_valid), 32'd1);
    check("mid data", out_data, 32'h11);
    check("mid credit stop", 32'(fifo_read), 32'd0);
    @(negedge clk); rst = 1'b1; flush = 1'b1; fifo_clr = 1'b1; #1;
    check("rst+flush read", 32'(fifo_read), 32'd0);
    @(negedge clk); rst = 1'b0; flush = 1'b0; fifo_clr = 1'b0; #1;
    check("post rst occ", 32'(occupancy), 32'd0);
    check("post rst valid", 32'(out_valid), 32'd0);
    check("post rst data", out_data, 32'd0);
    check("post rst read", 32'(fifo_read), 32'd0);
    @(negedge clk); ready = 1'b1; push(32'h44); #1;
    check("resume read", 32'(fifo_read), 32'd1);
    @(negedge clk); #1;
    check("resume latency", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    check("resume valid", 32'(out_valid), 32'd1);
    check("resume data", out_data, 32'h44);

    // Randomized traffic on the DEPTH=3 instance against an order/count model
    pushed = 0; delivered = 0; occm = 0; cyc = 0; infm = 1'b0;
    while (delivered < 200 && cyc < 5000) begin
      @(negedge clk);
      ready3 = 1'($urandom_range(0, 1));
      if (pushed < 200 && $urandom_range(0, 3) != 0) begin
        w = $urandom;
        push3(w);
        expq.push_back(w);
        pushed++;
      end
      #1;
      check("rand occ", 32'(occupancy3), 32'(occm));
      check("rand valid", 32'(out_valid3), 32'(occm != 0));
      check("rand occ bound", 32'(occupancy3 <= 2'd3), 32'd1);
      acc = (occm != 0) && ready3;
      if (acc && expq.size() > 0) begin
        check($sformatf("rand data %0d", delivered), out_data3, expq.pop_front());
        delivered++;
      end
      occm = occm + int'(infm) - int'(acc);
      infm = fifo_read3;
      cyc++;
    end
    check("rand delivered", 32'(delivered), 32'd200);
    check("rand leftover", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_pop_stage.md
Name: fifo_pop_stage

Overview:
- Downstream consumer of sync_fifo.
- Drives the FIFO's `read`, takes `rdData`, and re-presents the words as a registered valid/ready stream to the next pipeline stage.
- Holds data in a small credit-managed skid buffer, so no word is lost or duplicated under backpressure.
- Sustains one word per cycle when the consumer is always ready.

Parameters:
- WIDTH, 32, data word width; matches sync_fifo `wData`/`rdData`.
- DEPTH, 2, skid-buffer entries; legal range 2..8; full throughput requires DEPTH >= 2.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, localparam).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  sync_fifo `empty` flag.
- fifo_rdData  in  WIDTH  sync_fifo `rdData`; valid the cycle after `fifo_read`.
- fifo_read  out  1  pop request to sync_fifo.
- flush  in  1  discard all buffered and in-flight words.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  WIDTH  head of the skid buffer.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- occupancy  out  CW  number of words currently held in the buffer.

Behaviour:
- Reset (rst sampled high at a posedge):
  - out_valid=0, out_data=0, occupancy=0, in-flight flag=0.
  - Read/write pointers = 0.
  - fifo_read is 0 combinationally while rst=1.
- Upstream timing: sync_fifo has registered-read timing.
  - A pop issued in cycle N (fifo_read=1 at posedge N) presents its word on fifo_rdData during cycle N+1.
  - The in-flight flag is set at posedge N and cleared at posedge N+1, when the word is written into the buffer.
- Credit rule (combinational):
  - pop_out = out_valid && out_ready.
  - fifo_read = !rst && !flush && !fifo_empty && (occupancy + inflight − pop_out < DEPTH).
  - Paths from out_ready and fifo_empty to fifo_read are combinational by design.
- Latency: word popped in cycle N is written at posedge ending N+1 and is visible on out_valid/out_data in cycle N+2 (2-cycle latency).
- Throughput: with out_ready held at 1 and the FIFO non-empty, fifo_read stays high every cycle and out_valid stays high from N+2 on.
- Buffer:
  - Circular array of DEPTH entries with read and write pointers.
  - Both pointers wrap from DEPTH−1 to 0; DEPTH need not be a power of two.
  - out_data = entry[rdptr], registered storage, no bypass from fifo_rdData.
- Occupancy update:
  - +1 on arrival, −1 on pop_out, unchanged when both occur in the same cycle.
  - The credit rule guarantees an arrival never finds the buffer full. An arrival when occupancy==DEPTH is a design error, caught by the bound assertion.
- out_valid = (occupancy != 0).
  - Once asserted, out_valid and out_data stay stable until accepted or flushed.
- Flush (sampled at posedge):
  - occupancy=0, pointers=0, out_valid=0.
  - A word arriving in the flush cycle is dropped.
  - An in-flight word from a pop issued the cycle before flush is also dropped; the in-flight flag is cleared and its arrival is masked.
  - fifo_read=0 in the flush cycle.
  - Normal operation resumes the next cycle.
- Empty boundary: fifo_empty=1 gives no pop; buffered words still drain to the consumer.
- Simultaneous rst and flush: rst dominates; the result is identical to reset.
- Reset mid-transfer: the in-flight word is dropped, and the FIFO's own reset empties it.

Decomposition:
- Package `fifo_stage_pkg`:
  - WIDTH default constant.
  - `word_t` typedef, `logic [WIDTH-1:0]`.
  - Occupancy width function.
- Sub-module `skid_ram`:
  - DEPTH x WIDTH register array with write port (we, wptr, wdata) and async read port (rptr).
  - Pointer and credit logic stays in fifo_pop_stage.
- Companion bind module `asserts_fifo_pop_stage` checks:
  - no arrival when occupancy==DEPTH;
  - out_data stable while out_valid && !out_ready;
  - fifo_read never asserted while fifo_empty=1.

Test Plan:
1. Reset: rst=1 for 2 cycles, fifo_empty=0 → fifo_read=0, out_valid=0, occupancy=0; first fifo_read in the cycle after rst falls.
2. Streaming: FIFO preloaded with 0x1..0x8, out_ready=1 → fifo_read high for 8 consecutive cycles; out_data = 0x1..0x8 on 8 consecutive cycles, first value 2 cycles after the first read.
3. Backpressure: 0xA,0xB,0xC queued, out_ready=0 → fifo_read stops after 2 pops, occupancy=2, out_data=0xA held. Raising out_ready → 0xA,0xB,0xC delivered in order, none lost or duplicated.
4. Empty: FIFO holds a single word 0x55, then fifo_empty=1 → exactly one fifo_read pulse, one out_valid beat with 0x55, then out_valid=0.
5. Flush with a word in flight: pop issued in cycle N, flush=1 in cycle N+1 → word dropped, occupancy=0 and out_valid=0 at N+2; the next FIFO word 0x77 is delivered normally.
6. DEPTH=3 instance, random out_ready (50%), 200 words → output sequence equals input sequence, occupancy never exceeds 3, pointers wrap correctly.
